alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_core.sv | 38 +++
 rtl/alu_req_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: operand width,
// opcode values, FSM state encoding and the captured-operation record.
package alu_pkg;

  localparam int OPW = 16;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_XOR  = 4'd3,
    OP_XNOR = 4'd4,
    OP_INC  = 4'd5,
    OP_DEC  = 4'd6,
    OP_NOT  = 4'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [3:0]     sel;
  } alu_op_t;

  // Opcodes 8..15 are reserved and flagged as errors by the ALU.
  function automatic logic is_legal_op(input logic [3:0] sel);
    return (sel < 4'd8);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 16-bit ALU. Carry is only meaningful for ADD;
// illegal opcodes produce a zero result with the error flag set.
module alu_core
  import alu_pkg::*;
(
  input  logic [OPW-1:0] i_a,
  input  logic [OPW-1:0] i_b,
  input  logic [3:0]     i_sel,
  output logic [OPW-1:0] o_result,
  output logic           o_carry,
  output logic           o_err
);

  logic [OPW:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    o_err    = !is_legal_op(i_sel);
    case (opcode_e'(i_sel))
      OP_ADD: begin
        o_result = w_sum[OPW-1:0];
        o_carry  = w_sum[OPW];
      end
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_XNOR: o_result = ~(i_a ^ i_b);
      OP_INC:  o_result = i_a + OPW'(1);
      OP_DEC:  o_result = i_a - OPW'(1);
      OP_NOT:  o_result = ~i_a;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter granting one of two requesters access to a shared ALU;
// one operation in flight, response held until the consumer accepts it.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned RR_INIT = 0
)
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [OPW-1:0] req0_a,
  input  logic [OPW-1:0] req0_b,
  input  logic [OPW-1:0] req1_a,
  input  logic [OPW-1:0] req1_b,
  input  logic [3:0]     req0_sel,
  input  logic [3:0]     req1_sel,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [OPW-1:0] rsp_result,
  output logic           rsp_carry,
  output logic           rsp_err
);

  localparam logic PTR_INIT = (RR_INIT != 0);

  state_e         r_state;
  state_e         w_next_state;
  logic           r_ptr;
  alu_op_t        r_op;
  logic           r_id;
  logic           r_rsp_id;
  logic [OPW-1:0] r_rsp_result;
  logic           r_rsp_carry;
  logic           r_rsp_err;

  logic           w_grant0;
  logic           w_grant1;
  logic           w_rsp_fire;
  logic [OPW-1:0] w_alu_result;
  logic           w_alu_carry;
  logic           w_alu_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Readies are gated by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    w_next_state = r_state;
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rst_n) begin
          if (req0_valid && (!req1_valid || !r_ptr)) begin
            w_grant0 = 1'b1;
          end else if (req1_valid) begin
            w_grant1 = 1'b1;
          end
        end
        if (w_grant0 || w_grant1) begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_rsp_fire = (r_state == ST_RESP) && rsp_ready;

  // Pointer moves to the other requester only when a response is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PTR_INIT;
    end else if (w_rsp_fire) begin
      r_ptr <= ~r_rsp_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= '0;
      r_id <= 1'b0;
    end else if (w_grant0) begin
      r_op <= '{a: req0_a, b: req0_b, sel: req0_sel};
      r_id <= 1'b0;
    end else if (w_grant1) begin
      r_op <= '{a: req1_a, b: req1_b, sel: req1_sel};
      r_id <= 1'b1;
    end
  end

  alu_core u_alu (
    .i_a      (r_op.a),
    .i_b      (r_op.b),
    .i_sel    (r_op.sel),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry),
    .o_err    (w_alu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_id     <= r_id;
      r_rsp_result <= w_alu_result;
      r_rsp_carry  <= w_alu_carry;
      r_rsp_err    <= w_alu_err;
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed vector table, arbitration and reset
// sequences, then random traffic checked against an arithmetic reference.
module tb_alu_req_arbiter;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sel;
  } opT;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sel;
    logic [15:0] expResult;
    logic        expCarry;
    logic        expErr;
  } vecT;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_err;

  int   checks = 0;
  int   errors = 0;
  logic modelPtr;

  alu_req_arbiter #(.RR_INIT(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_sel   (req0_sel),
    .req1_sel   (req1_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference ALU from the opcode definitions, returns {err, carry, result}.
  function automatic logic [17:0] refAlu(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] sel);
    int unsigned ua, ub, r;
    logic c, e;
    ua = a;
    ub = b;
    c  = 1'b0;
    e  = 1'b0;
    case (sel)
      4'd0: begin r = ua + ub; c = (r >= 65536); r = r % 65536; end
      4'd1: r = (ua + 65536 - ub) % 65536;
      4'd2: r = ua & ub;
      4'd3: r = ua ^ ub;
      4'd4: r = (~(ua ^ ub)) & 32'hFFFF;
      4'd5: r = (ua + 1) % 65536;
      4'd6: r = (ua + 65535) % 65536;
      4'd7: r = (~ua) & 32'hFFFF;
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, c, r[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResp(input logic g, input logic [17:0] exp);
    checkOutput("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, g});
    checkOutput("rsp_result", {16'd0, rsp_result}, {16'd0, exp[15:0]});
    checkOutput("rsp_carry", {31'd0, rsp_carry}, {31'd0, exp[16]});
    checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp[17]});
    checkOutput("resp_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
  endtask

  // Runs one full operation starting at an IDLE negedge and ending at an IDLE negedge.
  task automatic applyStimulus(input logic v0, input logic v1, input opT o0, input opT o1,
                               input logic [17:0] exp0, input logic [17:0] exp1,
                               input int waitCycles, input logic earlyReady,
                               output logic servedId);
    logic g;
    logic [17:0] exp;
    g   = (v0 && v1) ? modelPtr : (v0 ? 1'b0 : 1'b1);
    exp = g ? exp1 : exp0;
    req0_valid = v0; req0_a = o0.a; req0_b = o0.b; req0_sel = o0.sel;
    req1_valid = v1; req1_a = o1.a; req1_b = o1.b; req1_sel = o1.sel;
    rsp_ready  = earlyReady && (waitCycles == 0);
    #1;
    checkOutput("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, (g == 1'b0)});
    checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, (g == 1'b1)});
    @(posedge clk);
    @(negedge clk);
    if (g == 1'b0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
    #1;
    checkOutput("exec_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
    checkOutput("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    #1;
    checkResp(g, exp);
    for (int i = 0; i < waitCycles; i++) begin
      @(negedge clk);
      #1;
      checkResp(g, exp);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checkOutput("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    modelPtr = ~g;
    servedId = g;
  endtask

  vecT  vecs[12];
  opT   nop, oA, oB, p0, p1;
  logic got;
  logic pend0, pend1;

  initial begin
    nop = '{a: 16'h0, b: 16'h0, sel: 4'h0};
    vecs[0]  = '{1'b0, 16'h000A, 16'h000B, 4'd0,  16'h0015, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 16'h1234, 4'd6,  16'hFFFF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'h1111, 16'h2222, 4'd10, 16'h0000, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0001, 4'd1,  16'hFFFF, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 16'hFFFF, 16'hABCD, 4'd5,  16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'hF0F0, 16'h3C3C, 4'd2,  16'h3030, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'hF0F0, 16'h3C3C, 4'd3,  16'hCCCC, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'hF0F0, 16'h3C3C, 4'd4,  16'h3333, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h1234, 16'hFFFF, 4'd7,  16'hEDCB, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'h5555, 16'h5555, 4'd15, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 16'h8000, 16'h8000, 4'd0,  16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 16'h0; req0_b = 16'h0; req0_sel = 4'h0;
    req1_a = 16'h0; req1_b = 16'h0; req1_sel = 4'h0;
    modelPtr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    checkOutput("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
    checkOutput("rst_rsp_carry", {31'd0, rsp_carry}, 32'd0);
    checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    oA = '{a: 16'h0001, b: 16'h0002, sel: 4'd0};
    oB = '{a: 16'h0010, b: 16'h0003, sel: 4'd1};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, oA, oB, 18'h00003, 18'h0000D, 0, 1'b0, got);
      checkOutput("alt_grant", {31'd0, got}, k % 2);
    end

    for (int i = 0; i < 12; i++) begin
      opT o;
      o = '{a: vecs[i].a, b: vecs[i].b, sel: vecs[i].sel};
      if (vecs[i].id == 1'b0)
        applyStimulus(1'b1, 1'b0, o, nop, {vecs[i].expErr, vecs[i].expCarry, vecs[i].expResult},
                      18'h0, 0, i[0], got);
      else
        applyStimulus(1'b0, 1'b1, nop, o, 18'h0,
                      {vecs[i].expErr, vecs[i].expCarry, vecs[i].expResult}, 0, i[0], got);
    end

    applyStimulus(1'b1, 1'b1, oA, oB, 18'h00003, 18'h0000D, 5, 1'b0, got);

    applyStimulus(1'b1, 1'b0, oA, nop, 18'h00003, 18'h0, 0, 1'b0, got);
    req1_valid = 1'b1; req1_a = 16'h0007; req1_b = 16'h0001; req1_sel = 4'd0;
    #1;
    checkOutput("pre_rst_grant1", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("midrst_rsp_result", {16'd0, rsp_result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelPtr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("postrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, oA, oB, 18'h00003, 18'h0000D, 0, 1'b0, got);
    checkOutput("postrst_ptr_init", {31'd0, got}, 32'd0);

    pend0 = 1'b0; pend1 = 1'b0;
    p0 = nop; p1 = nop;
    for (int it = 0; it < 200; it++) begin
      if (!pend0 && $urandom_range(0, 1) == 1) begin
        pend0 = 1'b1;
        p0 = '{a: 16'($urandom), b: 16'($urandom), sel: 4'($urandom_range(0, 15))};
      end
      if (!pend1 && $urandom_range(0, 1) == 1) begin
        pend1 = 1'b1;
        p1 = '{a: 16'($urandom), b: 16'($urandom), sel: 4'($urandom_range(0, 15))};
      end
      if (!pend0 && !pend1) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'($urandom_range(0, 1));
        #1;
        checkOutput("rand_idle_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
        checkOutput("rand_idle_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
      end else begin
        applyStimulus(pend0, pend1, p0, p1, refAlu(p0.a, p0.b, p0.sel), refAlu(p1.a, p1.b, p1.sel),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)), got);
        if (got == 1'b0) pend0 = 1'b0;
        else             pend1 = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
